// File: rtl/nyan_pkg.sv
// Shared types and defaults for the nyan sprite animation path.
// Latency: none (definitions only); backpressure: not applicable.
package nyan_pkg;

  typedef enum logic [1:0] {
    PAUSED       = 2'd0,
    RUNNING      = 2'd1,
    STEP_PENDING = 2'd2
  } state_t;

  // speed value is the right-shift applied to the phase length
  localparam logic [1:0] SPEED_X1 = 2'd0;
  localparam logic [1:0] SPEED_X2 = 2'd1;
  localparam logic [1:0] SPEED_X4 = 2'd2;
  localparam logic [1:0] SPEED_X8 = 2'd3;

  localparam int DEF_FRAMES_PER_PHASE = 16;
  localparam int DEF_BOB_PIXELS       = 5;
  localparam int DEF_SCROLL_STEP      = 2;

endpackage

// File: rtl/nyan_frame_divider.sv
// Counts animated frames and flags the frame that ends the current phase.
// Latency: toggle is combinational on count_en; no backpressure.
module nyan_frame_divider #(
  parameter int FRAMES_PER_PHASE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       count_en,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       toggle
);

  localparam int CW = $clog2(FRAMES_PER_PHASE);

  logic [CW-1:0] frame_cnt;
  logic [CW:0]   span;
  logic [CW:0]   last;

  // >= rather than == so a speed increase mid-phase ends the phase promptly
  assign span   = (CW+1)'(FRAMES_PER_PHASE) >> speed;
  assign last   = (span == '0) ? '0 : span - 1'b1;
  assign toggle = count_en && ({1'b0, frame_cnt} >= last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (clear || toggle) begin
      frame_cnt <= '0;
    end else if (count_en) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nyan_anim_ctrl.sv
// Frame-synchronous animation sequencer: phase, bob, image selects, scroll.
// Latency: outputs register on the frame_start edge; no backpressure.
module nyan_anim_ctrl
  import nyan_pkg::*;
#(
  parameter int FRAMES_PER_PHASE = DEF_FRAMES_PER_PHASE,
  parameter int BOB_PIXELS       = DEF_BOB_PIXELS,
  parameter int SCROLL_STEP      = DEF_SCROLL_STEP,
  parameter int VGA_WIDTH        = 640,
  parameter int X_BITS           = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              run,
  input  logic              step,
  input  logic [1:0]        speed,
  output logic              phase,
  output logic [3:0]        bob_y,
  output logic              feet_sel,
  output logic              tail_sel,
  output logic [X_BITS-1:0] scroll_x,
  output logic              update
);

  state_t state, state_nxt;

  logic            run_tick;
  logic            step_tick;
  logic            advance;
  logic            div_toggle;
  logic            phase_nxt;
  logic [X_BITS:0] scroll_sum;
  logic [X_BITS:0] scroll_wrap;

  assign run_tick  = (state == RUNNING) && run && frame_start;
  assign step_tick = (state == STEP_PENDING) && !run && frame_start;
  assign advance   = run_tick || step_tick;

  nyan_frame_divider #(
    .FRAMES_PER_PHASE(FRAMES_PER_PHASE)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .count_en(run_tick),
    .clear   (step_tick),
    .speed   (speed),
    .toggle  (div_toggle)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PAUSED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PAUSED: begin
        if (run) begin
          state_nxt = RUNNING;
        end else if (step) begin
          state_nxt = STEP_PENDING;
        end
      end
      RUNNING: begin
        if (!run) begin
          state_nxt = PAUSED;
        end
      end
      STEP_PENDING: begin
        if (run) begin
          state_nxt = RUNNING;
        end else if (frame_start) begin
          state_nxt = PAUSED;
        end
      end
      default: state_nxt = PAUSED;
    endcase
  end

  assign phase_nxt   = phase ^ (div_toggle | step_tick);
  assign scroll_sum  = {1'b0, scroll_x} + (X_BITS+1)'(SCROLL_STEP);
  assign scroll_wrap = (scroll_sum >= (X_BITS+1)'(VGA_WIDTH))
                     ? scroll_sum - (X_BITS+1)'(VGA_WIDTH) : scroll_sum;

  // decodes use phase_nxt so they land on the same edge as phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 1'b0;
      bob_y    <= 4'(BOB_PIXELS);
      feet_sel <= 1'b0;
      tail_sel <= 1'b0;
      scroll_x <= '0;
      update   <= 1'b0;
    end else begin
      update <= advance;
      if (advance) begin
        phase    <= phase_nxt;
        bob_y    <= phase_nxt ? 4'd0 : 4'(BOB_PIXELS);
        feet_sel <= phase_nxt;
        tail_sel <= phase_nxt;
        scroll_x <= scroll_wrap[X_BITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_nyan_anim_ctrl.sv
// Directed-vector bench for nyan_anim_ctrl with hand-computed expectations.
module tb_nyan_anim_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       run;
  logic       step;
  logic [1:0] speed;
  logic       phase;
  logic [3:0] bob_y;
  logic       feet_sel;
  logic       tail_sel;
  logic [9:0] scroll_x;
  logic       update;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  nyan_anim_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .run        (run),
    .step       (step),
    .speed      (speed),
    .phase      (phase),
    .bob_y      (bob_y),
    .feet_sel   (feet_sel),
    .tail_sel   (tail_sel),
    .scroll_x   (scroll_x),
    .update     (update)
  );

  task automatic frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic check_out(input string name, input logic exp_phase,
                           input logic [9:0] exp_scroll, input logic exp_update);
    logic [3:0] exp_bob;
    exp_bob = exp_phase ? 4'd0 : 4'd5;
    vectors++;
    if ({phase, bob_y, feet_sel, tail_sel, scroll_x, update} !==
        {exp_phase, exp_bob, exp_phase, exp_phase, exp_scroll, exp_update}) begin
      errors++;
      $display("FAIL %s: got phase=%0b bob=%0d feet=%0b tail=%0b scroll=%0d upd=%0b, want phase=%0b bob=%0d feet=%0b tail=%0b scroll=%0d upd=%0b",
               name, phase, bob_y, feet_sel, tail_sel, scroll_x, update,
               exp_phase, exp_bob, exp_phase, exp_phase, exp_scroll, exp_update);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 1'b0; run = 1'b0; step = 1'b0; speed = 2'd0;
    repeat (3) @(negedge clk);
    check_out("reset", 1'b0, 10'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    frame();
    check_out("paused_ignores_frame", 1'b0, 10'd0, 1'b0);
  endtask

  task automatic test_run_speed0();
    logic exp_ph;
    int   pulses = 0;
    @(negedge clk) run = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      frame();
      exp_ph = (k >= 16) ^ (k >= 32);
      if (update === 1'b1) pulses++;
      check_out($sformatf("run0_frame%0d", k), exp_ph, 10'(2 * k), 1'b1);
    end
    @(negedge clk);
    check_out("update_one_cycle", 1'b0, 10'd80, 1'b0);
    vectors++;
    if (pulses !== 40) begin
      errors++;
      $display("FAIL update_count: got %0d, want 40", pulses);
    end
  endtask

  task automatic test_speed_switch();
    frame(); frame();
    check_out("pre_switch_cnt10", 1'b0, 10'd84, 1'b1);
    @(negedge clk) speed = 2'd3;
    frame(); check_out("speed3_a", 1'b1, 10'd86, 1'b1);
    frame(); check_out("speed3_b", 1'b1, 10'd88, 1'b1);
    frame(); check_out("speed3_c", 1'b0, 10'd90, 1'b1);
    frame(); check_out("speed3_d", 1'b0, 10'd92, 1'b1);
    frame(); check_out("speed3_e", 1'b1, 10'd94, 1'b1);
  endtask

  task automatic test_step();
    @(negedge clk) begin run = 1'b0; speed = 2'd0; end
    @(negedge clk);
    frame(); check_out("pause_hold", 1'b1, 10'd94, 1'b0);
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    frame(); check_out("step_exec", 1'b0, 10'd96, 1'b1);
    frame(); check_out("step_after1", 1'b0, 10'd96, 1'b0);
    frame(); check_out("step_after2", 1'b0, 10'd96, 1'b0);
  endtask

  task automatic test_step_same_cycle();
    @(negedge clk) begin frame_start = 1'b1; step = 1'b1; end
    @(negedge clk) begin frame_start = 1'b0; step = 1'b0; end
    check_out("step_fs_same_cycle", 1'b0, 10'd96, 1'b0);
    frame(); check_out("step_latched_exec", 1'b1, 10'd98, 1'b1);
    frame(); check_out("step_latched_done", 1'b1, 10'd98, 1'b0);
  endtask

  task automatic test_wrap();
    logic ph_before;
    @(negedge clk) begin run = 1'b1; speed = 2'd3; end
    @(negedge clk);
    repeat (270) frame();
    vectors++;
    if (scroll_x !== 10'd638) begin
      errors++;
      $display("FAIL wrap_preload: got scroll=%0d, want 638", scroll_x);
    end
    ph_before = phase;
    frame();
    vectors++;
    if ({scroll_x, update} !== {10'd0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_to_zero: got scroll=%0d upd=%0b, want scroll=0 upd=1",
               scroll_x, update);
    end
    vectors++;
    if (bob_y !== (phase ? 4'd0 : 4'd5) || feet_sel !== phase || tail_sel !== phase) begin
      errors++;
      $display("FAIL wrap_decode: got phase=%0b bob=%0d feet=%0b tail=%0b, want decode of phase (prev %0b)",
               phase, bob_y, feet_sel, tail_sel, ph_before);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk) begin run = 1'b0; speed = 2'd0; end
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk) run = 1'b1;
    @(negedge clk);
    repeat (150) frame();
    check_out("preload_mid_phase", 1'b1, 10'd300, 1'b1);
    @(negedge clk) run = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_out("async_reset_now", 1'b0, 10'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    frame(); check_out("post_reset_paused", 1'b0, 10'd0, 1'b0);
    @(negedge clk) run = 1'b1;
    @(negedge clk);
    frame(); check_out("post_reset_first_run", 1'b0, 10'd2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_run_speed0();
    test_speed_switch();
    test_step();
    test_step_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
